// File: rtl/cae_csr_func_mux.sv
// Purpose: sequences csr_agent function accesses onto NUM_SLV register slaves, decoded from func_address.
// Latency: mapped read vld@T -> slv_rd_vld@T+1 -> func_ack@T+3 at the earliest; unmapped read func_ack@T+2.
// Backpressure: none; one access in flight, request pulses outside IDLE are dropped and flag proto_err.
// Optional: define CAE_CSR_MUX_STATS_EN to build the saturating timeout event counter on timeout_cnt.
module cae_csr_func_mux #(
    parameter int          NUM_SLV = 4,
    parameter int          SEL_LSB = 8,
    parameter int          SEL_W   = 3,
    parameter int          TIMEOUT = 255,
    parameter logic [63:0] TO_DATA = 64'hDEAD_C5C5_DEAD_C5C5
) (
    input  logic                    clk_csr,
    input  logic                    i_csr_reset,
    input  logic                    func_wr_vld,
    input  logic                    func_rd_vld,
    input  logic [15:0]             func_address,
    input  logic [63:0]             func_wr_data,
    output logic                    func_ack,
    output logic [63:0]             func_rd_data,
    output logic [NUM_SLV-1:0]      slv_wr_vld,
    output logic [NUM_SLV-1:0]      slv_rd_vld,
    output logic [15:0]             slv_address,
    output logic [63:0]             slv_wr_data,
    input  logic [NUM_SLV-1:0]      slv_ack,
    input  logic [64*NUM_SLV-1:0]   slv_rd_data,
    output logic                    proto_err,
    output logic [15:0]             timeout_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam logic [15:0]    TO_LAST     = 16'(TIMEOUT - 1);
    localparam logic [SEL_W:0] NUM_SLV_CMP = (SEL_W + 1)'(NUM_SLV);

    logic [1:0]         state;
    logic               op_rd;
    logic               mapped;
    logic [SEL_W-1:0]   sel;
    logic [15:0]        wait_cnt;

    logic               req_any;
    logic [SEL_W-1:0]   new_sel;
    logic               new_mapped;
    logic [NUM_SLV-1:0] new_oh;
    logic [NUM_SLV-1:0] sel_oh;
    logic [63:0]        sel_rd_data;
    logic               ack_hit;
    logic               wait_expired;

    function automatic logic [NUM_SLV-1:0] sel_onehot(input logic [SEL_W-1:0] s);
        logic [NUM_SLV-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (s == SEL_W'(i)) oh[i] = 1'b1;
        end
        return oh;
    endfunction

    assign req_any      = func_rd_vld | func_wr_vld;
    assign new_sel      = func_address[SEL_LSB +: SEL_W];
    assign new_mapped   = ({1'b0, new_sel} < NUM_SLV_CMP);
    assign new_oh       = sel_onehot(new_sel);
    assign sel_oh       = sel_onehot(sel);
    assign ack_hit      = |(slv_ack & sel_oh);
    assign wait_expired = (wait_cnt == TO_LAST);

    // Read-data mux: only the captured slave's slice can reach func_rd_data.
    always_comb begin
        sel_rd_data = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (sel_oh[i]) sel_rd_data = slv_rd_data[i*64 +: 64];
        end
    end

    // Access sequencer: IDLE -> REQ -> WAIT -> RESP; unmapped accesses use REQ as a dead slot and skip WAIT.
    always_ff @(posedge clk_csr) begin
        if (i_csr_reset) begin
            state        <= ST_IDLE;
            op_rd        <= 1'b0;
            mapped       <= 1'b0;
            sel          <= '0;
            wait_cnt     <= '0;
            func_ack     <= 1'b0;
            func_rd_data <= '0;
            slv_wr_vld   <= '0;
            slv_rd_vld   <= '0;
            slv_address  <= '0;
            slv_wr_data  <= '0;
            proto_err    <= 1'b0;
        end else begin
            slv_wr_vld <= '0;
            slv_rd_vld <= '0;
            func_ack   <= 1'b0;
            if (req_any && (state != ST_IDLE)) proto_err <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (req_any) begin
                        slv_address <= func_address;
                        slv_wr_data <= func_wr_data;
                        op_rd       <= func_rd_vld;
                        sel         <= new_sel;
                        mapped      <= new_mapped;
                        state       <= ST_REQ;
                        if (new_mapped) begin
                            if (func_rd_vld) slv_rd_vld <= new_oh;
                            else             slv_wr_vld <= new_oh;
                        end
                    end
                end
                ST_REQ: begin
                    wait_cnt <= '0;
                    if (mapped) begin
                        state <= ST_WAIT;
                    end else begin
                        state    <= ST_RESP;
                        func_ack <= op_rd;
                        if (op_rd) func_rd_data <= '0;
                    end
                end
                ST_WAIT: begin
                    if (ack_hit) begin
                        state    <= ST_RESP;
                        func_ack <= op_rd;
                        if (op_rd) func_rd_data <= sel_rd_data;
                    end else if (wait_expired) begin
                        state    <= ST_RESP;
                        func_ack <= op_rd;
                        if (op_rd) func_rd_data <= TO_DATA;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef CAE_CSR_MUX_STATS_EN
    logic to_evt;
    assign to_evt = (state == ST_WAIT) && !ack_hit && wait_expired;

    // Timeout event counter, saturating so a stuck slave cannot wrap it back to a small value.
    always_ff @(posedge clk_csr) begin
        if (i_csr_reset) begin
            timeout_cnt <= '0;
        end else if (to_evt && (timeout_cnt != 16'hFFFF)) begin
            timeout_cnt <= timeout_cnt + 16'd1;
        end
    end
`else
    assign timeout_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_cae_csr_func_mux.sv
module tb_cae_csr_func_mux;

    localparam int          NUM_SLV = 4;
    localparam int          TIMEOUT = 255;
    localparam logic [63:0] TO_DATA = 64'hDEAD_C5C5_DEAD_C5C5;

    logic                  clk_csr = 1'b0;
    logic                  i_csr_reset;
    logic                  func_wr_vld;
    logic                  func_rd_vld;
    logic [15:0]           func_address;
    logic [63:0]           func_wr_data;
    logic                  func_ack;
    logic [63:0]           func_rd_data;
    logic [NUM_SLV-1:0]    slv_wr_vld;
    logic [NUM_SLV-1:0]    slv_rd_vld;
    logic [15:0]           slv_address;
    logic [63:0]           slv_wr_data;
    logic [NUM_SLV-1:0]    slv_ack;
    logic [64*NUM_SLV-1:0] slv_rd_data;
    logic                  proto_err;
    logic [15:0]           timeout_cnt;

    int errors = 0;
    int checks = 0;

    // Reference state, derived from the access rules rather than the DUT.
    logic [63:0] model_rd_data;
    int          model_to_cnt;
    logic        model_proto;
    logic [63:0] slice_data [NUM_SLV];

    always #5 clk_csr = ~clk_csr;

    cae_csr_func_mux #(
        .NUM_SLV (NUM_SLV),
        .TIMEOUT (TIMEOUT),
        .TO_DATA (TO_DATA)
    ) dut (
        .clk_csr      (clk_csr),
        .i_csr_reset  (i_csr_reset),
        .func_wr_vld  (func_wr_vld),
        .func_rd_vld  (func_rd_vld),
        .func_address (func_address),
        .func_wr_data (func_wr_data),
        .func_ack     (func_ack),
        .func_rd_data (func_rd_data),
        .slv_wr_vld   (slv_wr_vld),
        .slv_rd_vld   (slv_rd_vld),
        .slv_address  (slv_address),
        .slv_wr_data  (slv_wr_data),
        .slv_ack      (slv_ack),
        .slv_rd_data  (slv_rd_data),
        .proto_err    (proto_err),
        .timeout_cnt  (timeout_cnt)
    );

    task automatic tick();
        @(posedge clk_csr);
        #1;
    endtask

    // Cycle (relative to the request cycle) at which the access completes.
    function automatic int exp_latency(input bit mapped, input int delay);
        if (!mapped) return 2;
        if (delay >= 0 && delay < TIMEOUT) return 3 + delay;
        return 2 + TIMEOUT;
    endfunction

    function automatic int exp_timeouts();
`ifdef CAE_CSR_MUX_STATS_EN
        return (model_to_cnt > 65535) ? 65535 : model_to_cnt;
`else
        return 0;
`endif
    endfunction

    // One access: delay = cycles after the slave pulse before the slave acks (-1 = never).
    task automatic run_txn(input logic [15:0] addr, input logic [63:0] wdata,
                           input bit rd, input bit wr, input int delay,
                           input bit noise, input bit late, input int inj,
                           input bit use_fixed, input logic [63:0] fixed, input string name);
        bit                 is_rd, is_wr, mapped, timed_out;
        int                 sel, lat, ack_at, acks, bad_pulses;
        logic [NUM_SLV-1:0] sel_mask, a, exp_rv, exp_wv;
        logic [63:0]        exp_data;
        is_rd     = rd;
        is_wr     = wr && !rd;
        sel       = int'(addr[10:8]);
        mapped    = sel < NUM_SLV;
        timed_out = mapped && !(delay >= 0 && delay < TIMEOUT);
        lat       = exp_latency(mapped, delay);
        sel_mask  = '0;
        if (mapped) sel_mask[sel] = 1'b1;
        for (int i = 0; i < NUM_SLV; i++) begin
            slice_data[i] = {$urandom, $urandom};
            if (use_fixed && i == sel) slice_data[i] = fixed;
            slv_rd_data[i*64 +: 64] = slice_data[i];
        end
        exp_data = !mapped ? 64'h0 : (timed_out ? TO_DATA : slice_data[sel]);
        exp_rv   = (is_rd) ? sel_mask : '0;
        exp_wv   = (is_wr) ? sel_mask : '0;
        ack_at = -1; acks = 0; bad_pulses = 0;
        func_rd_vld  = rd;
        func_wr_vld  = wr;
        func_address = addr;
        func_wr_data = wdata;
        for (int n = 1; n <= lat + 1; n++) begin
            tick();
            if (n == 1) begin
                func_rd_vld = 1'b0;
                func_wr_vld = 1'b0;
                checks++;
                if (slv_rd_vld !== exp_rv || slv_wr_vld !== exp_wv) begin
                    errors++;
                    $display("FAIL %s slave pulse: rd_vld=%b wr_vld=%b, expected rd_vld=%b wr_vld=%b",
                             name, slv_rd_vld, slv_wr_vld, exp_rv, exp_wv);
                end
                checks++;
                if (slv_address !== addr || slv_wr_data !== wdata) begin
                    errors++;
                    $display("FAIL %s slave addr/data: %h/%h, expected %h/%h",
                             name, slv_address, slv_wr_data, addr, wdata);
                end
            end else if ((slv_rd_vld | slv_wr_vld) != '0) begin
                bad_pulses++;
            end
            if (inj > 0 && n == inj) begin
                func_rd_vld  = 1'b1;
                func_address = 16'h0200;
                model_proto  = 1'b1;
            end else if (inj > 0 && n == inj + 1) begin
                func_rd_vld  = 1'b0;
                func_address = addr;
            end
            if (func_ack) begin
                acks++;
                if (ack_at < 0) ack_at = n;
            end
            a = noise ? (NUM_SLV'($urandom) & ~sel_mask) : '0;
            if (mapped && delay >= 0 && n == 2 + delay) a = a | sel_mask;
            if (late && mapped && n == lat) a = a | sel_mask;
            slv_ack = a;
        end
        slv_ack = '0;
        if (timed_out) model_to_cnt++;
        if (is_rd) model_rd_data = exp_data;
        checks++;
        if (bad_pulses != 0) begin
            errors++;
            $display("FAIL %s extra slave pulses: %0d, expected 0", name, bad_pulses);
        end
        checks++;
        if (is_rd && (acks != 1 || ack_at != lat)) begin
            errors++;
            $display("FAIL %s func_ack: %0d pulses first at T+%0d, expected 1 at T+%0d", name, acks, ack_at, lat);
        end else if (!is_rd && acks != 0) begin
            errors++;
            $display("FAIL %s write func_ack: %0d pulses, expected 0", name, acks);
        end
        checks++;
        if (func_rd_data !== model_rd_data) begin
            errors++;
            $display("FAIL %s func_rd_data: %h, expected %h", name, func_rd_data, model_rd_data);
        end
        checks++;
        if (slv_address !== addr) begin
            errors++;
            $display("FAIL %s slv_address held: %h, expected %h", name, slv_address, addr);
        end
        checks++;
        if (proto_err !== model_proto) begin
            errors++;
            $display("FAIL %s proto_err: %b, expected %b", name, proto_err, model_proto);
        end
        checks++;
        if (int'(timeout_cnt) != exp_timeouts()) begin
            errors++;
            $display("FAIL %s timeout_cnt: %0d, expected %0d", name, timeout_cnt, exp_timeouts());
        end
    endtask

    task automatic check_zero_outputs(input string name);
        checks++;
        if (func_ack !== 1'b0 || func_rd_data !== 64'h0 || slv_wr_vld !== '0 || slv_rd_vld !== '0 ||
            slv_address !== 16'h0 || slv_wr_data !== 64'h0 || proto_err !== 1'b0 || timeout_cnt !== 16'h0) begin
            errors++;
            $display("FAIL %s outputs: ack=%b rd=%h wv=%b rv=%b addr=%h wd=%h perr=%b tcnt=%h, expected all 0",
                     name, func_ack, func_rd_data, slv_wr_vld, slv_rd_vld, slv_address, slv_wr_data,
                     proto_err, timeout_cnt);
        end
    endtask

    task automatic test_reset();
        i_csr_reset = 1'b1;
        func_wr_vld = 1'b0; func_rd_vld = 1'b0;
        func_address = '0; func_wr_data = '0;
        slv_ack = '0; slv_rd_data = '0;
        model_rd_data = '0; model_to_cnt = 0; model_proto = 1'b0;
        repeat (3) tick();
        check_zero_outputs("reset");
        i_csr_reset = 1'b0;
        tick();
        check_zero_outputs("post_reset_idle");
    endtask

    task automatic test_directed();
        run_txn(16'h0105, 64'h0,  1'b1, 1'b0, 0,  1'b0, 1'b0, 0, 1'b1, 64'h1234, "read_sel1");
        run_txn(16'h0300, 64'hA5, 1'b0, 1'b1, 0,  1'b0, 1'b0, 0, 1'b0, 64'h0,    "write_sel3");
        run_txn(16'h0700, 64'h0,  1'b1, 1'b0, 0,  1'b0, 1'b0, 0, 1'b0, 64'h0,    "read_unmapped");
        run_txn(16'h0200, 64'h0,  1'b1, 1'b0, -1, 1'b0, 1'b1, 0, 1'b0, 64'h0,    "read_timeout");
        run_txn(16'h0102, 64'h0,  1'b1, 1'b1, 1,  1'b0, 1'b0, 0, 1'b0, 64'h0,    "both_vld_is_read");
        run_txn(16'h0000, 64'h0,  1'b1, 1'b0, TIMEOUT - 1, 1'b0, 1'b0, 0, 1'b0, 64'h0, "ack_on_last_wait");
    endtask

    task automatic test_proto_err();
        run_txn(16'h0104, 64'h0, 1'b1, 1'b0, 3, 1'b1, 1'b0, 2, 1'b0, 64'h0, "proto_during_wait");
        run_txn(16'h0011, 64'h0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 64'h0, "proto_sticky");
    endtask

    task automatic test_random();
        logic [15:0] addr;
        int          delay;
        bit          rd;
        for (int k = 0; k < 40; k++) begin
            addr  = 16'($urandom);
            rd    = 1'($urandom);
            delay = (k % 15 == 7) ? -1 : int'($urandom_range(0, 6));
            run_txn(addr, {$urandom, $urandom}, rd, !rd || 1'($urandom), delay,
                    1'($urandom), 1'($urandom), 0, 1'b0, 64'h0, "random");
        end
    endtask

    task automatic test_reset_in_wait();
        int acks;
        func_rd_vld = 1'b1; func_address = 16'h0200;
        tick();
        func_rd_vld = 1'b0;
        repeat (4) tick();
        i_csr_reset = 1'b1;
        tick();
        i_csr_reset = 1'b0;
        model_rd_data = '0; model_to_cnt = 0; model_proto = 1'b0;
        check_zero_outputs("reset_in_wait");
        acks = 0;
        for (int n = 0; n < TIMEOUT + 8; n++) begin
            tick();
            if (func_ack) acks++;
        end
        checks++;
        if (acks != 0) begin
            errors++;
            $display("FAIL reset_abandon func_ack: %0d pulses, expected 0", acks);
        end
        run_txn(16'h0205, 64'h0, 1'b1, 1'b0, 2, 1'b0, 1'b0, 0, 1'b0, 64'h0, "read_after_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_proto_err();
        test_random();
        test_reset_in_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
